cdc_fifo_wptr_full: RTL and testbench

CDC_FIFO_WPTR_FULL -- requirements
Module: cdc_fifo_wptr_full

---
 rtl/cdc_fifo_wptr_full_pkg.sv | 20 ++
 rtl/cdc_fifo_gray2bin.sv | 22 ++
 rtl/cdc_fifo_wptr_full.sv | 113 +++++++++++
 tb/tb_cdc_fifo_wptr_full.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cdc_fifo_wptr_full_pkg.sv
// ---------------------------------------------------------------------------
// cdc_fifo_wptr_full_pkg
// Purpose : shared types for the write-side pointer/flag block of the
//           asynchronous FIFO.
// Contents: wflags_t   - bundle of the registered write-side status flags
//           WFLAGS_RESET - value the flag bundle takes on reset
// ---------------------------------------------------------------------------
package cdc_fifo_wptr_full_pkg;

  // Registered write-side status flags, kept together so that reset and
  // next-state logic treat them as one unit.
  typedef struct packed {
    logic full;
    logic almost_full;
    logic overflow;
  } wflags_t;

  localparam wflags_t WFLAGS_RESET = '0;

endpackage : cdc_fifo_wptr_full_pkg

// File: rtl/cdc_fifo_gray2bin.sv
// ---------------------------------------------------------------------------
// cdc_fifo_gray2bin
// Purpose : purely combinational Gray-to-binary converter, shared by the
//           write-side and read-side pointer blocks of the async FIFO.
// Ports   : i_gray [WIDTH-1:0]  Gray-coded input
//           o_bin  [WIDTH-1:0]  binary equivalent
// ---------------------------------------------------------------------------
module cdc_fifo_gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  // Each binary bit is the XOR reduction of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
    end
  endgenerate

endmodule : cdc_fifo_gray2bin

// File: rtl/cdc_fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// cdc_fifo_wptr_full
// Purpose : write-domain pointer and flag logic of an asynchronous FIFO.
//           Maintains the binary/Gray write pointer, generates registered
//           full / almost-full flags, a conservative occupancy count and a
//           sticky overflow flag. All logic runs on w_clk.
// Ports   : w_clk           write-domain clock
//           w_rst_n         synchronous active-low reset
//           w_inc           write request
//           w_q2_rptr       Gray read pointer, already synchronised to w_clk
//           w_clr_overflow  clears the sticky overflow flag
//           w_full          registered full flag
//           w_almost_full   registered almost-full flag
//           w_ptr           registered Gray write pointer (to read domain)
//           w_addr          binary RAM write address
//           w_count         registered conservative occupancy (0..DEPTH)
//           w_overflow      sticky: write requested while full
// ---------------------------------------------------------------------------
module cdc_fifo_wptr_full
  import cdc_fifo_wptr_full_pkg::*;
#(
  parameter int ADDR_SIZE          = 4,
  parameter int ALMOST_FULL_MARGIN = 2
) (
  input  logic                 w_clk,
  input  logic                 w_rst_n,
  input  logic                 w_inc,
  input  logic [ADDR_SIZE:0]   w_q2_rptr,
  input  logic                 w_clr_overflow,
  output logic                 w_full,
  output logic                 w_almost_full,
  output logic [ADDR_SIZE:0]   w_ptr,
  output logic [ADDR_SIZE-1:0] w_addr,
  output logic [ADDR_SIZE:0]   w_count,
  output logic                 w_overflow
);

  localparam int DEPTH = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] AF_THRESH =
    (ADDR_SIZE + 1)'(DEPTH - ALMOST_FULL_MARGIN);

  // State
  logic [ADDR_SIZE:0] r_bin;
  logic [ADDR_SIZE:0] r_gray;
  logic [ADDR_SIZE:0] r_count;
  wflags_t            r_flags;

  // Next-state
  logic               w_write_ok;
  logic               w_overflow_hit;
  logic [ADDR_SIZE:0] w_bin_next;
  logic [ADDR_SIZE:0] w_gray_next;
  logic [ADDR_SIZE:0] w_rbin;
  logic [ADDR_SIZE:0] w_count_next;
  logic [ADDR_SIZE:0] w_full_target;
  wflags_t            w_flags_next;

  // Read pointer in binary, for the occupancy subtraction.
  cdc_fifo_gray2bin #(
    .WIDTH (ADDR_SIZE + 1)
  ) u_rptr_g2b (
    .i_gray (w_q2_rptr),
    .o_bin  (w_rbin)
  );

  // The accept decision uses the registered flag only, so a read advance
  // arriving this cycle cannot un-block a write until the next edge.
  assign w_write_ok     = w_inc & ~r_flags.full;
  assign w_overflow_hit = w_inc &  r_flags.full;

  assign w_bin_next   = r_bin + {{ADDR_SIZE{1'b0}}, w_write_ok};
  assign w_gray_next  = w_bin_next ^ (w_bin_next >> 1);
  assign w_count_next = w_bin_next - w_rbin;

  // Full when the write pointer is exactly one lap ahead: in Gray code that
  // means the top two bits differ and the rest match.
  assign w_full_target = {~w_q2_rptr[ADDR_SIZE:ADDR_SIZE-1],
                          w_q2_rptr[ADDR_SIZE-2:0]};

  always_comb begin
    w_flags_next             = r_flags;
    w_flags_next.full        = (w_gray_next == w_full_target);
    // OR-ing in full keeps almost-full asserted even if the margin
    // parameter were pushed to its extreme.
    w_flags_next.almost_full = (w_count_next >= AF_THRESH) |
                               w_flags_next.full;
    // An overflowing write on the same edge wins over the clear request.
    w_flags_next.overflow    = w_overflow_hit |
                               (r_flags.overflow & ~w_clr_overflow);
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_count <= '0;
      r_flags <= WFLAGS_RESET;
    end else begin
      r_bin   <= w_bin_next;
      r_gray  <= w_gray_next;
      r_count <= w_count_next;
      r_flags <= w_flags_next;
    end
  end

  assign w_full        = r_flags.full;
  assign w_almost_full = r_flags.almost_full;
  assign w_overflow    = r_flags.overflow;
  assign w_ptr         = r_gray;
  assign w_addr        = r_bin[ADDR_SIZE-1:0];
  assign w_count       = r_count;

endmodule : cdc_fifo_wptr_full

// File: tb/tb_cdc_fifo_wptr_full.sv
module tb_cdc_fifo_wptr_full;

  localparam int AS = 4;

  typedef struct packed {
    logic [AS:0]   ptr;
    logic [AS-1:0] addr;
    logic [AS:0]   count;
    logic          full;
    logic          af;
    logic          ovf;
  } exp_t;

  logic          w_clk = 1'b0;
  logic          w_rst_n;
  logic          w_inc;
  logic [AS:0]   w_q2_rptr;
  logic          w_clr_overflow;
  logic          w_full;
  logic          w_almost_full;
  logic [AS:0]   w_ptr;
  logic [AS-1:0] w_addr;
  logic [AS:0]   w_count;
  logic          w_overflow;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];

  // Reference state: integer write position and registered flags.
  int   m_wp   = 0;
  logic m_full = 1'b0;
  logic m_ovf  = 1'b0;

  always #5 w_clk = ~w_clk;

  cdc_fifo_wptr_full #(
    .ADDR_SIZE          (AS),
    .ALMOST_FULL_MARGIN (2)
  ) dut (
    .w_clk          (w_clk),
    .w_rst_n        (w_rst_n),
    .w_inc          (w_inc),
    .w_q2_rptr      (w_q2_rptr),
    .w_clr_overflow (w_clr_overflow),
    .w_full         (w_full),
    .w_almost_full  (w_almost_full),
    .w_ptr          (w_ptr),
    .w_addr         (w_addr),
    .w_count        (w_count),
    .w_overflow     (w_overflow)
  );

  function automatic int gray_to_int(input logic [AS:0] g);
    logic [AS:0] b;
    b[AS] = g[AS];
    for (int i = AS - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  function automatic logic [AS:0] int_to_gray(input int v);
    logic [AS:0] b;
    b = v[AS:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, push the modelled result, clock, pop and compare.
  task automatic step(input logic inc, input logic [AS:0] q2,
                      input logic clr, input logic rst_n);
    exp_t e;
    int   occ;
    w_inc          = inc;
    w_q2_rptr      = q2;
    w_clr_overflow = clr;
    w_rst_n        = rst_n;
    if (!rst_n) begin
      m_wp   = 0;
      m_full = 1'b0;
      m_ovf  = 1'b0;
      e      = '0;
    end else begin
      if (inc && m_full) m_ovf = 1'b1;
      else if (clr)      m_ovf = 1'b0;
      if (inc && !m_full) m_wp = (m_wp + 1) % 32;
      occ    = (m_wp - gray_to_int(q2) + 32) % 32;
      m_full = (occ == 16);
      e.ptr   = int_to_gray(m_wp);
      e.addr  = m_wp[AS-1:0];
      e.count = occ[AS:0];
      e.full  = m_full;
      e.af    = (occ >= 14);
      e.ovf   = m_ovf;
    end
    exp_q.push_back(e);
    @(posedge w_clk);
    #1;
    e = exp_q.pop_front();
    check("ptr",   32'(w_ptr),         32'(e.ptr));
    check("addr",  32'(w_addr),        32'(e.addr));
    check("count", 32'(w_count),       32'(e.count));
    check("full",  32'(w_full),        32'(e.full));
    check("afull", 32'(w_almost_full), 32'(e.af));
    check("ovf",   32'(w_overflow),    32'(e.ovf));
    $display("t=%0t inc=%b q2=%b clr=%b rst_n=%b -> ptr=%b addr=%0d cnt=%0d full=%b af=%b ovf=%b",
             $time, inc, q2, clr, rst_n, w_ptr, w_addr, w_count, w_full,
             w_almost_full, w_overflow);
  endtask

  initial begin
    int rp;
    w_rst_n = 1'b0; w_inc = 1'b0; w_q2_rptr = '0; w_clr_overflow = 1'b0;
    @(negedge w_clk);

    // Reset with a write request pending.
    step(1'b1, 5'b0, 1'b1, 1'b0);
    check("rst_ptr",   32'(w_ptr),   0);
    check("rst_count", 32'(w_count), 0);
    check("rst_full",  32'(w_full),  0);

    // Fill to almost-full, then full.
    for (int i = 0; i < 14; i++) step(1'b1, 5'b0, 1'b0, 1'b1);
    check("af14_count", 32'(w_count),       14);
    check("af14_af",    32'(w_almost_full), 1);
    check("af14_full",  32'(w_full),        0);
    for (int i = 0; i < 2; i++) step(1'b1, 5'b0, 1'b0, 1'b1);
    check("full_flag", 32'(w_full), 1);
    check("full_ptr",  32'(w_ptr),  32'h18);
    check("full_addr", 32'(w_addr), 0);

    // Writes while full: pointer frozen, overflow sticky.
    for (int i = 0; i < 3; i++) step(1'b1, 5'b0, 1'b0, 1'b1);
    check("ovf_ptr",   32'(w_ptr),      32'h18);
    check("ovf_count", 32'(w_count),    16);
    check("ovf_set",   32'(w_overflow), 1);
    // Clear request coincident with another overflowing write: stays set.
    step(1'b1, 5'b0, 1'b1, 1'b1);
    check("ovf_clr_collide", 32'(w_overflow), 1);
    step(1'b0, 5'b0, 1'b1, 1'b1);
    check("ovf_cleared", 32'(w_overflow), 0);

    // Reader catches up completely.
    step(1'b0, 5'b11000, 1'b0, 1'b1);
    check("drain_full",  32'(w_full),        0);
    check("drain_af",    32'(w_almost_full), 0);
    check("drain_count", 32'(w_count),       0);

    // Wrap through 2**(ADDR_SIZE+1).
    for (int i = 0; i < 16; i++) step(1'b1, 5'b11000, 1'b0, 1'b1);
    check("wrap_ptr",   32'(w_ptr),   0);
    check("wrap_addr",  32'(w_addr),  0);
    check("wrap_full",  32'(w_full),  1);
    check("wrap_count", 32'(w_count), 16);

    // Concurrent reads and writes with a lagging reader.
    rp = 16;
    for (int i = 0; i < 40; i++) begin
      if (rp != m_wp && $urandom_range(0, 1) == 1) rp = (rp + 1) % 32;
      step(1'($urandom_range(0, 1)), int_to_gray(rp), 1'b0, 1'b1);
    end

    // Reset mid-stream at count 9.
    step(1'b0, 5'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 5'b0, 1'b0, 1'b1);
    check("mid_count9", 32'(w_count), 9);
    step(1'b1, 5'b0, 1'b1, 1'b0);
    check("mid_rst_ptr",   32'(w_ptr),   0);
    check("mid_rst_count", 32'(w_count), 0);
    step(1'b1, 5'b0, 1'b0, 1'b1);
    check("first_write_ptr", 32'(w_ptr), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_cdc_fifo_wptr_full
